serial_frame_arbiter: RTL and testbench
=======================================

Name: serial_frame_arbiter

Overview:
- Shares one two-wire scl/sda output link between N_REQ requesters; each requester posts a 4-bit code.
- Round-robin arbitration, one frame per grant, frames serialized MSB first.
- Frame format is fixed: start condition, 4 data slots, 1 pad slot, stop condition.
- Drives the 4-bit-code / one-hot decoder receivers downstream. Lives in the system clock domain and divides clk to form scl.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- HALF, 4, clk cycles per scl half-period and per start/stop phase (>=1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- req  in  N_REQ  per-requester request level; held high until granted.
- code  in  4*N_REQ  flattened codes; requester i uses code[4i+3:4i].
- grant  out  N_REQ  one-hot, one-cycle pulse when requester i's code is latched.
- busy  out  1  high from grant cycle until return to IDLE.
- frame_done  out  1  one-cycle pulse in the last STOP cycle.
- last_code  out  4  code of the most recently granted frame.
- scl  out  1  serial clock, registered.
- sda  out  1  serial data, registered.

Behaviour:
- Reset (rst_n=0 at a rising clk): next cycle scl=1, sda=1, grant=0, busy=0, frame_done=0, last_code=0, rr pointer=0, FSM=IDLE, phase counter=0.
- Reset mid-frame aborts the frame immediately. The receiver sees no stop; this is acceptable.
- All outputs are registered and change only on clk rising edge.
- IDLE: scl=1, sda=1.
  - If any req bit is set, pick the first set bit searching from the rr pointer upward, with wrap.
  - In the same cycle: grant[i]=1 for one cycle, latch code_i into shift register and last_code, set busy=1, then go to START.
  - rr pointer becomes (i+1) mod N_REQ.
  - req bits are not sampled in any other state.
  - A req dropped before grant is simply not serviced.
- Phases: each phase lasts exactly HALF clk cycles, counted by a phase counter (0..HALF-1).
  - START: scl=1, sda=0. This is the start condition: sda falls while scl is high.
  - SLOT k, k=0..4, two sub-phases each:
    - LOW: scl=0; sda = data bit at sub-phase entry. Slots 0..3 carry code[3],[2],[1],[0]. Slot 4 (pad) drives sda=0.
    - HIGH: scl=1, sda held. Receiver samples on the scl rising edge.
  - STOP_LOW: scl=0, sda=0.
  - STOP_SETUP: scl=1, sda=0.
  - STOP: scl=1, sda=1. This is the stop condition: sda rises while scl is high. frame_done=1 in the final cycle of STOP. Then go to IDLE with busy=0.
- sda changes only while scl=0, except at the start and stop transitions.
- Frame length: 14 phases x HALF cycles, from the cycle after grant to the cycle busy drops.
- Minimum gap between frames: 1 IDLE cycle (the grant cycle).
  - Back-to-back requests give one IDLE cycle with scl=1, sda=1, then the next START.
- A requester keeping req high after its grant is served again only after the other pending requesters.
- Latched code is immune to code/req changes after the grant cycle.
- HALF=1 must work: every phase lasts one cycle.

Test Plan:
- Single request, HALF=2, req=0001, code0=4'b1010 -> grant=0001 for 1 cycle; last_code=1010. Sda sampled at the five scl rising edges reads 1,0,1,0,0. frame_done fires 28 cycles after grant; busy is high for 29 cycles.
- Simultaneous req=0101, codes 4'h3 and 4'hC, rr pointer=0 -> first grant=0001 (frame bits 0011). Next IDLE gives grant=0100 (bits 1100). rr pointer then =3.
- All four req held high continuously -> grant order 0,1,2,3,0. Exactly one IDLE cycle between frames; no grant while busy=1.
- Reset asserted in SLOT 2 HIGH -> next cycle scl=1, sda=1, busy=0, last_code=0, rr=0. No frame_done pulse.
- req0 raised then dropped while another frame is in progress -> req0 never granted; grant for other requesters unaffected.
- HALF=1, code=4'hF -> 14-cycle frame; scl toggles every cycle through the slots. Sda is high over slots 0..3 and low in the pad slot. Start/stop edges occur only with scl=1.

Source files
------------

// File: rtl/serial_frame_arbiter.sv
// rtl/serial_frame_arbiter.sv - round-robin arbiter serializing 4-bit codes onto a shared scl/sda link
module serial_frame_arbiter #(
  parameter int N_REQ = 4,
  parameter int HALF  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [4*N_REQ-1:0] code,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               frame_done,
  output logic [3:0]         last_code,
  output logic               scl,
  output logic               sda
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

  // Output registers are loaded from the current state, so the visible
  // waveform trails the state register by one cycle; the grant cycle itself
  // therefore shows the idle levels scl=1/sda=1.
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SLOT_LO,
    S_SLOT_HI,
    S_STOP_LO,
    S_STOP_SU,
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       slot_q, slot_d;
  logic [3:0]       shreg_q, shreg_d;
  logic [PW-1:0]    rr_q, rr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             scl_q, scl_d;
  logic             sda_q, sda_d;
  logic [3:0]       last_q, last_d;

  logic             found;
  logic [PW-1:0]    pick;
  logic [3:0]       pick_code;
  logic             phase_end;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s[PW-1:0];
  endfunction

  // Round-robin search: first asserted req at or above the pointer, with wrap.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && req[wrap_add(rr_q, j)]) begin
        found = 1'b1;
        pick  = wrap_add(rr_q, j);
      end
    end
  end

  assign pick_code = code[4*pick +: 4];
  assign phase_end = (cnt_q == CW'(HALF - 1));

  // Frame sequencing and next values of all registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    shreg_d = shreg_q;
    rr_d    = rr_q;
    last_d  = last_q;
    grant_d = '0;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    scl_d   = 1'b1;
    sda_d   = 1'b1;

    if (state_q != S_IDLE) begin
      cnt_d = phase_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        busy_d = found;
        cnt_d  = '0;
        if (found) begin
          grant_d[pick] = 1'b1;
          shreg_d       = pick_code;
          last_d        = pick_code;
          rr_d          = wrap_add(pick, 1);
          slot_d        = '0;
          state_d       = S_START;
        end
      end
      S_START: begin
        sda_d = 1'b0;
        if (phase_end) state_d = S_SLOT_LO;
      end
      S_SLOT_LO: begin
        scl_d = 1'b0;
        sda_d = shreg_q[3];
        if (phase_end) state_d = S_SLOT_HI;
      end
      S_SLOT_HI: begin
        sda_d = shreg_q[3];
        if (phase_end) begin
          // Zeros shift in behind the code, so the pad slot drives sda low.
          shreg_d = {shreg_q[2:0], 1'b0};
          if (slot_q == 3'd4) begin
            state_d = S_STOP_LO;
          end else begin
            slot_d  = slot_q + 3'd1;
            state_d = S_SLOT_LO;
          end
        end
      end
      S_STOP_LO: begin
        scl_d = 1'b0;
        sda_d = 1'b0;
        if (phase_end) state_d = S_STOP_SU;
      end
      S_STOP_SU: begin
        sda_d = 1'b0;
        if (phase_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (phase_end) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      slot_q  <= '0;
      shreg_q <= '0;
      rr_q    <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      shreg_q <= shreg_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
      last_q  <= last_d;
    end
  end

  assign grant      = grant_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign last_code  = last_q;
  assign scl        = scl_q;
  assign sda        = sda_q;

endmodule

// File: tb/tb_serial_frame_arbiter.sv
// tb/tb_serial_frame_arbiter.sv - self-checking bench for serial_frame_arbiter
module tb_serial_frame_arbiter;

  localparam int H = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  req, req1;
  logic [15:0] code, code1;
  logic [3:0]  grant, grant1;
  logic        busy, busy1, frame_done, frame_done1, scl, scl1, sda, sda1;
  logic [3:0]  last_code, last_code1;

  serial_frame_arbiter #(.N_REQ(4), .HALF(H)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .code(code), .grant(grant),
    .busy(busy), .frame_done(frame_done), .last_code(last_code),
    .scl(scl), .sda(sda)
  );

  serial_frame_arbiter #(.N_REQ(4), .HALF(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .code(code1), .grant(grant1),
    .busy(busy1), .frame_done(frame_done1), .last_code(last_code1),
    .scl(scl1), .sda(sda1)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          chk_en = 1'b0;

  // Model: expected {grant,busy,scl,sda,frame_done,last_code} per future cycle.
  logic [11:0] mq[$];
  int          m_rr = 0;
  int          m_pick;
  logic [3:0]  m_lc = 4'h0;
  logic [11:0] m_exp, m_act;

  int          w, fd, bl;
  logic [3:0]  g;
  logic [4:0]  bits;

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int j = 0; j < 4; j++) begin
      if (r[(p + j) % 4]) return (p + j) % 4;
    end
    return -1;
  endfunction

  // Whole frame as the link should look: grant cycle, then 14 phases of H cycles.
  task automatic push_frame(input logic [3:0] gr, input logic [3:0] c);
    logic [1:0] ph [0:13];
    logic       b;
    ph[0] = 2'b10;
    for (int k = 0; k < 5; k++) begin
      b = (k < 4) ? c[3 - k] : 1'b0;
      ph[1 + 2*k] = {1'b0, b};
      ph[2 + 2*k] = {1'b1, b};
    end
    ph[11] = 2'b00;
    ph[12] = 2'b10;
    ph[13] = 2'b11;
    mq.push_back({gr, 1'b1, 1'b1, 1'b1, 1'b0, c});
    for (int p = 0; p < 14; p++) begin
      for (int h = 0; h < H; h++) begin
        mq.push_back({4'b0000, 1'b1, ph[p], (p == 13 && h == H - 1), c});
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      m_rr = 0;
      m_lc = 4'h0;
    end else if (mq.size() == 0 && req != 4'b0000) begin
      m_pick = rr_pick(req, m_rr);
      m_lc   = code[4*m_pick +: 4];
      push_frame(4'b0001 << m_pick, m_lc);
      m_rr   = (m_pick + 1) % 4;
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      if (mq.size() > 0) m_exp = mq.pop_front();
      else m_exp = {4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, m_lc};
      m_act = {grant, busy, scl, sda, frame_done, last_code};
      n_cmp++;
      if (m_act !== m_exp) begin
        n_bad++;
        $display("FAIL model t=%0t got g=%b b=%b scl=%b sda=%b fd=%b lc=%h exp g=%b b=%b scl=%b sda=%b fd=%b lc=%h",
                 $time, m_act[11:8], m_act[7], m_act[6], m_act[5], m_act[4], m_act[3:0],
                 m_exp[11:8], m_exp[7], m_exp[6], m_exp[5], m_exp[4], m_exp[3:0]);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int waited, output logic [3:0] gr);
    waited = 0;
    gr = 4'b0000;
    for (int k = 0; k < 60; k++) begin
      cyc1();
      waited++;
      if (grant != 4'b0000) begin
        gr = grant;
        break;
      end
    end
    if (gr == 4'b0000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL grant_timeout got none exp a grant within 60 cycles");
    end
  endtask

  task automatic run_frame(output int fd_at, output int blen, output logic [4:0] bv);
    logic prev;
    int   nb;
    fd_at = -1;
    blen  = busy ? 1 : 0;
    bv    = 5'b00000;
    nb    = 0;
    prev  = scl;
    for (int n = 1; n <= 100; n++) begin
      cyc1();
      if (busy) blen++;
      if (!prev && scl && nb < 5) begin
        bv = {bv[3:0], sda};
        nb++;
      end
      prev = scl;
      if (frame_done) begin
        fd_at = n;
        break;
      end
    end
  endtask

  logic [0:14] scl_x = 15'b110101010101011;
  logic [0:14] sda_x = 15'b101111111100001;
  logic [3:0]  exp_g [0:4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  bit          seen;

  initial begin
    rst_n = 1'b0; req = '0; req1 = '0; code = '0; code1 = '0;
    cyc1(); cyc1();
    chk_en = 1'b1;
    check("rst_scl", scl, 1);
    check("rst_sda", sda, 1);
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_last", last_code, 0);
    rst_n = 1'b1;

    // single request, code 1010
    code = 16'h000A; req = 4'b0001;
    wait_grant(w, g);
    check("t1_grant", g, 4'b0001);
    check("t1_wait", w, 1);
    check("t1_last", last_code, 4'hA);
    req = 4'b0000;
    run_frame(fd, bl, bits);
    check("t1_fd_at", fd, 28);
    check("t1_busy_len", bl, 29);
    check("t1_bits", bits, 5'b10100);
    cyc1();
    check("t1_busy_after", busy, 0);

    // two simultaneous requesters from a fresh pointer
    rst_n = 1'b0; cyc1(); rst_n = 1'b1;
    code = 16'h0C03; req = 4'b0101;
    wait_grant(w, g);
    check("t2_grant0", g, 4'b0001);
    check("t2_last0", last_code, 4'h3);
    req = 4'b0100;
    run_frame(fd, bl, bits);
    check("t2_bits0", bits, 5'b00110);
    wait_grant(w, g);
    check("t2_gap", w, 1);
    check("t2_grant2", g, 4'b0100);
    check("t2_last2", last_code, 4'hC);
    req = 4'b0000;
    run_frame(fd, bl, bits);
    check("t2_bits2", bits, 5'b11000);
    req = 4'b1001;
    wait_grant(w, g);
    check("t2_rr3", g, 4'b1000);
    req = 4'b0000;
    run_frame(fd, bl, bits);

    // all requesters held high
    rst_n = 1'b0; cyc1(); rst_n = 1'b1;
    code = 16'h4321; req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(w, g);
      check($sformatf("t3_grant%0d", k), g, exp_g[k]);
      check($sformatf("t3_gap%0d", k), w, 1);
      check($sformatf("t3_last%0d", k), last_code, (k % 4) + 1);
      if (k == 4) req = 4'b0000;
      run_frame(fd, bl, bits);
      check($sformatf("t3_fd%0d", k), fd, 28);
    end

    // reset in slot 2 high
    rst_n = 1'b0; cyc1(); rst_n = 1'b1;
    code = 16'h0050; req = 4'b0010;
    wait_grant(w, g);
    check("t4_grant", g, 4'b0010);
    req = 4'b0000;
    repeat (13) cyc1();
    rst_n = 1'b0;
    cyc1();
    check("t4_scl", scl, 1);
    check("t4_sda", sda, 1);
    check("t4_busy", busy, 0);
    check("t4_last", last_code, 0);
    check("t4_fd", frame_done, 0);
    rst_n = 1'b1;
    code = 16'h0760; req = 4'b0110;
    wait_grant(w, g);
    check("t4_rr0", g, 4'b0010);
    req = 4'b0000;
    run_frame(fd, bl, bits);
    check("t4_fd_at", fd, 28);

    // req0 pulses during another frame and is never served
    code = 16'h0900; req = 4'b0100;
    wait_grant(w, g);
    check("t5_grant", g, 4'b0100);
    req = 4'b0000;
    repeat (3) cyc1();
    req = 4'b0001;
    repeat (4) cyc1();
    req = 4'b0000;
    run_frame(fd, bl, bits);
    check("t5_fd_at", fd, 21);
    repeat (3) cyc1();
    code = 16'hB000; req = 4'b1000;
    wait_grant(w, g);
    check("t5_grant3", g, 4'b1000);
    check("t5_last", last_code, 4'hB);
    req = 4'b0000;
    run_frame(fd, bl, bits);

    // HALF=1 instance, code F
    code1 = 16'h000F; req1 = 4'b0001;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc1();
      if (grant1 != 4'b0000) begin
        seen = 1'b1;
        break;
      end
    end
    check("h1_grant_seen", seen, 1);
    check("h1_grant", grant1, 4'b0001);
    check("h1_last", last_code1, 4'hF);
    req1 = 4'b0000;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) cyc1();
      if (i < 15)
        check($sformatf("h1_cyc%0d", i), {scl1, sda1, busy1, frame_done1},
              {scl_x[i], sda_x[i], 1'b1, (i == 14)});
      else
        check("h1_after", {scl1, sda1, busy1, frame_done1}, 4'b1100);
    end

    repeat (3) cyc1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish exp finish before 200000");
    $fatal(1);
  end

endmodule
